// File: rtl/alu_pkg.sv
// Shared op codes and FSM encoding for the sequential ALU and the ALU control decoder.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_SUBU = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational add/sub/logic/compare for every non-shift op; shift and unused codes yield 0.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            less
);

  logic [XLEN-1:0] diff;
  logic            lt_signed;
  logic            lt_unsigned;

  assign diff        = a - b;
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  always_comb begin
    result = '0;
    less   = 1'b0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB: begin
        result = diff;
        less   = lt_signed;
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT: begin
        result = {{(XLEN-1){1'b0}}, lt_signed};
        less   = lt_signed;
      end
      OP_SLTU: begin
        result = {{(XLEN-1){1'b0}}, lt_unsigned};
        less   = lt_unsigned;
      end
      OP_SUBU: begin
        result = diff;
        less   = lt_unsigned;
      end
      default: begin
        result = '0;
        less   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops via alu_comb_core, shifts iterated one bit per cycle.
module seq_alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_operation,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            less,
  output logic [1:0]      fsm_state
);

  localparam int SHW = $clog2(XLEN);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE, and result/zero/less
  // stay stable from the rise of out_valid until the transfer edge.

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            less_q, less_d;

  logic [XLEN-1:0] core_result;
  logic            core_less;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] work_shifted;

  alu_comb_core #(.XLEN(XLEN)) u_core (
    .op     (alu_operation),
    .a      (operand_a),
    .b      (operand_b),
    .result (core_result),
    .less   (core_less)
  );

  assign shamt = operand_b[SHW-1:0];

  always_comb begin
    work_shifted = work_q;
    case (op_q)
      OP_SLL:  work_shifted = {work_q[XLEN-2:0], 1'b0};
      OP_SRL:  work_shifted = {1'b0, work_q[XLEN-1:1]};
      OP_SRA:  work_shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: work_shifted = work_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    less_d   = less_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_shift_op(alu_operation) && (shamt != '0)) begin
            state_d = ST_SHIFT;
            work_d  = operand_a;
            cnt_d   = shamt;
            op_d    = alu_operation;
          end else if (is_shift_op(alu_operation)) begin
            // Zero shift amount: the operand passes straight through.
            state_d  = ST_DONE;
            result_d = operand_a;
            zero_d   = (operand_a == '0);
            less_d   = 1'b0;
          end else begin
            state_d  = ST_DONE;
            result_d = core_result;
            zero_d   = (core_result == '0);
            less_d   = core_less;
          end
        end
      end
      ST_SHIFT: begin
        work_d = work_shifted;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d  = ST_DONE;
          result_d = work_shifted;
          zero_d   = (work_shifted == '0);
          less_d   = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q   <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      less_q   <= 1'b0;
    end else begin
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      less_q   <= less_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign less      = less_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: reset, single-cycle ops, shifts, backpressure, reset abort.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_operation;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        less;
  logic [1:0]  fsm_state;

  int checks;
  int failures;

  seq_alu #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_operation (alu_operation),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero          (zero),
    .less          (less),
    .fsm_state     (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one request at a negedge, accept edge follows, then scramble operands.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_operation = op;
    operand_a     = a;
    operand_b     = b;
    in_valid      = 1'b1;
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    operand_a     = $urandom;
    operand_b     = $urandom;
    alu_operation = 4'($urandom_range(0, 15));
  endtask

  // Latency in the 1 = "visible right after the accept edge" sense; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b0 || less !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: out_valid=%b result=%h zero=%b less=%b want 0/0/0/0",
               out_valid, result, zero, less);
    end
    checks++;
    if (in_ready !== 1'b1 || fsm_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_idle: in_ready=%b state=%0d want 1/%0d", in_ready, fsm_state, ST_IDLE);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_cycle();
    // op, a, b, expected result, zero, less
    logic [3:0]  ops [9]  = '{4'b0000, 4'b0001, 4'b1010, 4'b0110, 4'b0111,
                              4'b0010, 4'b0011, 4'b0100, 4'b1100};
    logic [31:0] as  [9]  = '{32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFFB,
                              32'hF0F01234, 32'hF0F01234, 32'hF0F01234, 32'h12345678};
    logic [31:0] bs  [9]  = '{32'h1, 32'h3, 32'h3, 32'h3, 32'h3,
                              32'h0FF0FF00, 32'h0FF0FF00, 32'h0FF0FF00, 32'h1};
    logic [31:0] rs  [9]  = '{32'h0, 32'hFFFFFFF8, 32'hFFFFFFF8, 32'h1, 32'h0,
                              32'h00F01200, 32'hFFF0FF34, 32'hFF00ED34, 32'h0};
    logic        zs  [9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        ls  [9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 9; i++) begin
      send(ops[i], as[i], bs[i]);
      wait_valid(lat);
      checks++;
      if (lat !== 1) begin
        failures++;
        $display("FAIL op%b_latency: got %0d want 1", ops[i], lat);
      end
      checks++;
      if (result !== rs[i] || zero !== zs[i] || less !== ls[i]) begin
        failures++;
        $display("FAIL op%b_value: result=%h zero=%b less=%b want %h/%b/%b",
                 ops[i], result, zero, less, rs[i], zs[i], ls[i]);
      end
      consume();
    end
  endtask

  task automatic test_shift();
    logic [3:0]  ops [6] = '{4'b1001, 4'b1000, 4'b0101, 4'b1000, 4'b1001, 4'b0101};
    logic [31:0] as  [6] = '{32'h80000000, 32'h12345678, 32'h00000001, 32'h80000000,
                             32'h40000000, 32'h000000FF};
    logic [31:0] bs  [6] = '{32'h24, 32'h20, 32'h1F, 32'h1F, 32'h2, 32'h18};
    logic [31:0] rs  [6] = '{32'hF8000000, 32'h12345678, 32'h80000000, 32'h00000001,
                             32'h10000000, 32'hFF000000};
    int          lats[6] = '{5, 1, 32, 32, 3, 25};
    int lat;
    for (int i = 0; i < 6; i++) begin
      send(ops[i], as[i], bs[i]);
      wait_valid(lat);
      checks++;
      if (lat !== lats[i]) begin
        failures++;
        $display("FAIL shift%0d_latency: got %0d want %0d", i, lat, lats[i]);
      end
      checks++;
      if (result !== rs[i] || less !== 1'b0 || zero !== 1'b0) begin
        failures++;
        $display("FAIL shift%0d_value: result=%h zero=%b less=%b want %h/0/0",
                 i, result, zero, less, rs[i]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(OP_ADD, 32'd5, 32'd7);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd12) begin
        failures++;
        $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b result=%h want 1/0/0000000c",
                 i, out_valid, in_ready, result);
      end
      @(negedge clk);
    end
    consume();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_to_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    send(OP_ADD, 32'd1, 32'd1);
    wait_valid(lat);
    checks++;
    if (lat !== 1 || result !== 32'd2) begin
      failures++;
      $display("FAIL after_release_add: lat=%0d result=%h want 1/00000002", lat, result);
    end
    consume();
  endtask

  task automatic test_reset_mid_shift();
    int highs;
    int lat;
    send(OP_SLL, 32'h1, 32'd20);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      failures++;
      $display("FAIL midshift_reset: out_valid=%b in_ready=%b result=%h want 0/1/0",
               out_valid, in_ready, result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) highs++;
    end
    checks++;
    if (highs !== 0) begin
      failures++;
      $display("FAIL midshift_no_result: out_valid high %0d cycles want 0", highs);
    end
    send(OP_ADD, 32'd3, 32'd4);
    wait_valid(lat);
    checks++;
    if (lat !== 1 || result !== 32'd7 || zero !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_add: lat=%0d result=%h zero=%b want 1/00000007/0", lat, result, zero);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    send(OP_SUB, 32'd10, 32'd10);
    wait_valid(lat);
    checks++;
    if (result !== 32'h0 || zero !== 1'b1 || less !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: result=%h zero=%b less=%b want 0/1/0", result, zero, less);
    end
    consume();
    send(OP_SLTU, 32'd1, 32'hFFFFFFFF);
    wait_valid(lat);
    checks++;
    if (lat !== 1 || result !== 32'h1 || less !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second: lat=%0d result=%h less=%b want 1/00000001/1", lat, result, less);
    end
    consume();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    alu_operation = 4'b0;
    operand_a     = 32'h0;
    operand_b     = 32'h0;
    test_reset();
    test_single_cycle();
    test_shift();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
